mem_lsu_master: RTL and testbench
=================================

// Module: mem_lsu_master
// PURPOSE
//  Load/store initiator for the word-addressed data memory (ports address/dataIn/wEn/memOut).
//  Takes one byte/half/word load or store from the core datapath and drives the memory side.
//  Sub-word stores are done as read-modify-write.
//  Sits between the core execute stage and the data memory; one request in flight at a time.
// PARAMETERS
//  MEM_AW   5   log2 of memory depth in words; word index >= 2**MEM_AW is out of range
// PORTS
//  clk           in   1   single clock, all state updates on posedge
//  rst           in   1   asynchronous, active-high reset
//  req_valid     in   1   request present
//  req_ready     out  1   block idle, can accept; transfer when req_valid&&req_ready at posedge
//  req_we        in   1   1=store, 0=load
//  req_size      in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned  in   1   load zero-extends when 1, sign-extends when 0
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, right-justified
//  rsp_valid     out  1   one-cycle completion pulse (loads and stores)
//  rsp_rdata     out  32  extended load data, valid with rsp_valid; 0 for stores/errors
//  rsp_err       out  1   misaligned/illegal size/out of range, valid with rsp_valid
//  mem_address   out  32  word index = req_addr[31:2]
//  mem_dataIn    out  32  write data to memory
//  mem_wEn       out  1   memory write enable; memory writes at the posedge where it is high
//  mem_memOut    in   32  memory read data; valid one cycle after mem_address is driven
// BEHAVIOUR
//  - Reset: state IDLE; req_ready, rsp_valid, rsp_err, mem_wEn = 0; rsp_rdata, mem_address, mem_dataIn = 0.
//  - req_ready, mem_wEn: registered outputs.
//  - req_ready rises at the first posedge after rst falls.
//  - Async rst at any time forces mem_wEn=0 at once, so a pending write never happens.
//  - States: IDLE, RD, CAP, WR, RESP.
//  - IDLE: req_ready=1. On acceptance, latch the request and set req_ready=0.
//    - Error (size 11, half with addr[0]=1, word with addr[1:0]!=0, or word index >= 2**MEM_AW) -> RESP with err=1.
//      No memory access in this case.
//    - Load or sub-word store -> RD.
//    - Word store -> WR.
//  - RD: drive mem_address; mem_wEn=0 -> CAP.
//  - CAP: mem_memOut valid.
//    - Load: extract the lane, extend it and register it into rsp_rdata -> RESP.
//    - Store: merge the lane into mem_memOut and register it into mem_dataIn -> WR.
//  - WR: mem_wEn=1 for exactly one cycle; mem_address held -> RESP.
//  - RESP: rsp_valid=1 for one cycle -> IDLE, req_ready=1 again. No response backpressure.
//  - Latency from the acceptance edge to rsp_valid high:
//    - error: 1 cycle
//    - word store: 2 cycles
//    - load: 3 cycles
//    - sub-word store: 4 cycles
//  - Lanes:
//    - byte = bits [8*a+7:8*a] with a = addr[1:0]
//    - half = bits [16*h+15:16*h] with h = addr[1]
//    - extension from bit 7 or 15 unless req_unsigned.
//    - Store merge replaces only the addressed lane with req_wdata[7:0] or [15:0].
//  - req_* inputs are ignored when req_ready=0. Request fields are latched, so inputs may change after acceptance.
// STRUCTURE
//  - Shared package:
//    - SIZE_B/SIZE_H/SIZE_W encodings
//    - state encoding localparams
//    - lane extract/merge functions (reused by the core writeback)
//  - One combinational sub-module, mem_lane_align:
//    - inputs: word, addr[1:0], size, unsigned, wdata
//    - outputs: extracted load value, merged store word
//  - Top: FSM plus request/response registers.
// TESTING (bench instantiates the block with the existing memory model, MEM_AW=5)
//  1. SW 0x10 data 0xDEADBEEF, then LW 0x10
//     -> mem_address=4, one mem_wEn pulse; rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 3 cycles after accept.
//  2. SW 0x0C 0x11223344; SB 0x0F data 0x80
//     -> word 3 = 0x80223344; LB 0x0F = 0xFFFFFF80; LBU 0x0F = 0x00000080.
//  3. SH 0x0E data 0xA5A5 over 0x11223344 -> word = 0xA5A53344; LH 0x0E = 0xFFFFA5A5; LHU 0x0E = 0x0000A5A5.
//  4. Misaligned and illegal requests: LW 0x11, SH 0x01, size 11, addr 0x80
//     -> rsp_err=1 one cycle after accept; mem_wEn never high; memory unchanged.
//  5. req_valid held high with back-to-back SW 0x00/0x04
//     -> second accepted only after the first rsp_valid; both words correct, no lost request.
//  6. Assert rst during WR of a SB to 0x08 (old word 0x55555555)
//     -> mem_wEn drops immediately; word stays 0x55555555; req_ready=1 one edge after rst release.

Source files
------------

// File: rtl/mem_lsu_master_pkg.sv
// Shared load/store definitions: size codes, FSM encoding, request record, lane extract/merge.
// Pure declarations and combinational helpers.
package mem_lsu_master_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_CAP  = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_RD   = ST_RD,
    S_CAP  = ST_CAP,
    S_WR   = ST_WR,
    S_RESP = ST_RESP
  } state_t;

  // Only the fields needed after acceptance; the word index goes straight to mem_address.
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  lane;
    logic [31:0] wdata;
  } req_t;

  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] a,
                                               input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*a +: 8];
    h = word[16*a[1] +: 16];
    case (size)
      SIZE_B:  return uns ? {24'b0, b} : {{24{b[7]}}, b};
      SIZE_H:  return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [1:0] a,
                                             input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] r;
    r = word;
    case (size)
      SIZE_B:  r[8*a +: 8] = wdata[7:0];
      SIZE_H:  r[16*a[1] +: 16] = wdata[15:0];
      default: r = wdata;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane steering between a memory word and a byte/half/word access.
// Combinational, zero latency; no flow control.
module mem_lane_align
  import mem_lsu_master_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  assign ld_data = lane_extract(word, addr, size, uns);
  assign st_word = lane_merge(word, addr, size, wdata);

endmodule

// File: rtl/mem_lsu_master.sv
// Single-outstanding load/store initiator with read-modify-write for sub-word stores.
// Latency err 1 / SW 2 / load 3 / sub-store 4 cycles; req_ready low while busy, no rsp backpressure.
module mem_lsu_master
  import mem_lsu_master_pkg::*;
#(
  parameter int MEM_AW = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_dataIn,
  output logic        mem_wEn,
  input  logic [31:0] mem_memOut
);

  state_t      state, state_nxt;
  req_t        req_q, req_nxt;
  logic        ready_nxt, wen_nxt, vld_nxt, err_nxt, req_err;
  logic [31:0] rdata_nxt, addr_nxt, din_nxt, ld_data, st_word;

  assign req_err = (req_size == 2'b11)
                || (req_size == SIZE_H && req_addr[0])
                || (req_size == SIZE_W && req_addr[1:0] != 2'b00)
                || (req_addr[31:MEM_AW+2] != '0);

  mem_lane_align u_align (
    .word    (mem_memOut),
    .addr    (req_q.lane),
    .size    (req_q.size),
    .uns     (req_q.uns),
    .wdata   (req_q.wdata),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  always_comb begin
    state_nxt = state;
    req_nxt   = req_q;
    ready_nxt = 1'b0;
    wen_nxt   = 1'b0;
    vld_nxt   = 1'b0;
    err_nxt   = rsp_err;
    rdata_nxt = rsp_rdata;
    addr_nxt  = mem_address;
    din_nxt   = mem_dataIn;
    case (state)
      S_IDLE: begin
        ready_nxt = 1'b1;
        if (req_valid && req_ready) begin
          ready_nxt     = 1'b0;
          req_nxt.we    = req_we;
          req_nxt.size  = req_size;
          req_nxt.uns   = req_unsigned;
          req_nxt.lane  = req_addr[1:0];
          req_nxt.wdata = req_wdata;
          rdata_nxt     = '0;
          err_nxt       = 1'b0;
          if (req_err) begin
            // Rejected requests never touch the memory port.
            state_nxt = S_RESP;
            vld_nxt   = 1'b1;
            err_nxt   = 1'b1;
          end else begin
            addr_nxt = {2'b00, req_addr[31:2]};
            if (req_we && req_size == SIZE_W) begin
              state_nxt = S_WR;
              wen_nxt   = 1'b1;
              din_nxt   = req_wdata;
            end else begin
              state_nxt = S_RD;
            end
          end
        end
      end
      S_RD:  state_nxt = S_CAP;
      S_CAP: begin
        if (req_q.we) begin
          state_nxt = S_WR;
          wen_nxt   = 1'b1;
          din_nxt   = st_word;
        end else begin
          state_nxt = S_RESP;
          vld_nxt   = 1'b1;
          rdata_nxt = ld_data;
        end
      end
      S_WR: begin
        state_nxt = S_RESP;
        vld_nxt   = 1'b1;
      end
      S_RESP: begin
        state_nxt = S_IDLE;
        ready_nxt = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // mem_wEn clears asynchronously with rst, so an interrupted write is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q       <= '0;
      req_ready   <= 1'b0;
      mem_wEn     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
      mem_address <= '0;
      mem_dataIn  <= '0;
    end else begin
      req_q       <= req_nxt;
      req_ready   <= ready_nxt;
      mem_wEn     <= wen_nxt;
      rsp_valid   <= vld_nxt;
      rsp_err     <= err_nxt;
      rsp_rdata   <= rdata_nxt;
      mem_address <= addr_nxt;
      mem_dataIn  <= din_nxt;
    end
  end

endmodule

// File: tb/tb_mem_lsu_master.sv
// Bench for mem_lsu_master: vector table through a response scoreboard, plus back-to-back and reset-during-write sequences.
module tb_mem_lsu_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, mem_wEn;
  logic [31:0] rsp_rdata, mem_address, mem_dataIn, mem_memOut;

  always #5 clk = ~clk;

  mem_lsu_master #(.MEM_AW(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_address(mem_address), .mem_dataIn(mem_dataIn),
    .mem_wEn(mem_wEn), .mem_memOut(mem_memOut)
  );

  // Word memory model: synchronous read, write on the edge where mem_wEn is high.
  logic [31:0] mem  [0:31];
  logic [31:0] snap [0:31];
  int          wr_cnt = 0;
  logic [31:0] wr_addr = '0;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (mem_wEn) begin
      mem[mem_address[4:0]] <= mem_dataIn;
      wr_cnt++;
      wr_addr = mem_address;
    end
    mem_memOut <= mem[mem_address[4:0]];
  end

  typedef struct {
    bit        we;
    bit [1:0]  size;
    bit        uns;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] exp_rdata;
    bit        exp_err;
    int        exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cyc %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        check("rsp_latency", cyc - e.acc + 1, e.lat);
      end
    end
  end

  function automatic vec_t mk(bit we, bit [1:0] sz, bit uns, bit [31:0] a, bit [31:0] wd,
                              bit [31:0] er, bit ee, int lat);
    vec_t v;
    v.we = we; v.size = sz; v.uns = uns; v.addr = a; v.wdata = wd;
    v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat;
    return v;
  endfunction

  // Leaves req_valid high on return so callers can chain back-to-back requests.
  task automatic send(input vec_t v, input bit push);
    int g;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    g = 0;
    while (req_ready !== 1'b1 && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (g >= 40) begin
      n_total++;
      $display("FAIL send_timeout: got req_ready=%b expected 1", req_ready);
    end else begin
      if (push) sb.push_back('{v.exp_rdata, v.exp_err, v.exp_lat, cyc + 1});
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 60) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout: got %0d pending responses expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  localparam int NV = 22;
  vec_t vt[NV];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, diffs, ta, tb_acc, g;
    bit exp_wr;
    vt[0]  = mk(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2);
    vt[1]  = mk(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3);
    vt[2]  = mk(1, 2'b10, 0, 32'h0C, 32'h11223344, 32'h0, 0, 2);
    vt[3]  = mk(1, 2'b00, 0, 32'h0F, 32'h00000080, 32'h0, 0, 4);
    vt[4]  = mk(0, 2'b00, 0, 32'h0F, 32'h0, 32'hFFFFFF80, 0, 3);
    vt[5]  = mk(0, 2'b00, 1, 32'h0F, 32'h0, 32'h00000080, 0, 3);
    vt[6]  = mk(0, 2'b10, 0, 32'h0C, 32'h0, 32'h80223344, 0, 3);
    vt[7]  = mk(1, 2'b10, 0, 32'h0C, 32'h11223344, 32'h0, 0, 2);
    vt[8]  = mk(1, 2'b01, 0, 32'h0E, 32'h0000A5A5, 32'h0, 0, 4);
    vt[9]  = mk(0, 2'b01, 0, 32'h0E, 32'h0, 32'hFFFFA5A5, 0, 3);
    vt[10] = mk(0, 2'b01, 1, 32'h0E, 32'h0, 32'h0000A5A5, 0, 3);
    vt[11] = mk(0, 2'b10, 0, 32'h0C, 32'h0, 32'hA5A53344, 0, 3);
    vt[12] = mk(0, 2'b01, 0, 32'h0C, 32'h0, 32'h00003344, 0, 3);
    vt[13] = mk(0, 2'b00, 0, 32'h0E, 32'h0, 32'hFFFFFFA5, 0, 3);
    vt[14] = mk(0, 2'b00, 1, 32'h0D, 32'h0, 32'h00000033, 0, 3);
    vt[15] = mk(0, 2'b10, 0, 32'h11, 32'h0, 32'h0, 1, 1);
    vt[16] = mk(1, 2'b01, 0, 32'h01, 32'h0000FFFF, 32'h0, 1, 1);
    vt[17] = mk(0, 2'b11, 0, 32'h00, 32'h0, 32'h0, 1, 1);
    vt[18] = mk(1, 2'b11, 0, 32'h10, 32'h12345678, 32'h0, 1, 1);
    vt[19] = mk(0, 2'b10, 0, 32'h80, 32'h0, 32'h0, 1, 1);
    vt[20] = mk(1, 2'b00, 0, 32'h80, 32'h000000FF, 32'h0, 1, 1);
    vt[21] = mk(1, 2'b10, 0, 32'h7C, 32'h0BADF00D, 32'h0, 0, 2);

    for (int i = 0; i < 32; i++) mem[i] = '0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'h0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
    check("rst_mem_wEn", {31'b0, mem_wEn}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_mem_address", mem_address, 32'h0);
    check("rst_mem_dataIn", mem_dataIn, 32'h0);
    rst = 1'b0;
    #1 check("ready_before_edge", {31'b0, req_ready}, 32'h0);
    @(posedge clk);
    #1 check("ready_after_release", {31'b0, req_ready}, 32'h1);

    for (int i = 0; i < NV; i++) begin
      w0 = wr_cnt;
      for (int k = 0; k < 32; k++) snap[k] = mem[k];
      send(vt[i], 1'b1);
      req_valid = 1'b0;
      drain();
      exp_wr = vt[i].we && !vt[i].exp_err;
      check($sformatf("wr_count_%0d", i), wr_cnt - w0, exp_wr ? 32'd1 : 32'd0);
      if (i == 0) check("sw_mem_address", wr_addr, 32'd4);
      if (vt[i].exp_err) begin
        diffs = 0;
        for (int k = 0; k < 32; k++) if (mem[k] !== snap[k]) diffs++;
        check($sformatf("err_mem_unchanged_%0d", i), diffs, 32'd0);
      end
    end
    check("mem_word4", mem[4], 32'hDEADBEEF);
    check("mem_word3", mem[3], 32'hA5A53344);
    check("mem_word31", mem[31], 32'h0BADF00D);

    // Back-to-back stores with req_valid held high throughout.
    send(mk(1, 2'b10, 0, 32'h00, 32'hCAFE0001, 32'h0, 0, 2), 1'b1);
    ta = cyc;
    send(mk(1, 2'b10, 0, 32'h04, 32'hCAFE0002, 32'h0, 0, 2), 1'b1);
    tb_acc = cyc;
    req_valid = 1'b0;
    drain();
    check("b2b_accept_gap", tb_acc - ta, 32'd3);
    check("b2b_word0", mem[0], 32'hCAFE0001);
    check("b2b_word1", mem[1], 32'hCAFE0002);

    // Reset while the sub-word store is in its write cycle.
    send(mk(1, 2'b10, 0, 32'h08, 32'h55555555, 32'h0, 0, 2), 1'b1);
    req_valid = 1'b0;
    drain();
    send(mk(1, 2'b00, 0, 32'h08, 32'h00000012, 32'h0, 0, 4), 1'b0);
    req_valid = 1'b0;
    g = 0;
    while (mem_wEn !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("sb_reaches_wr", {31'b0, mem_wEn}, 32'h1);
    w0 = wr_cnt;
    rst = 1'b1;
    #1 check("rst_drops_wEn", {31'b0, mem_wEn}, 32'h0);
    check("rst_drops_ready", {31'b0, req_ready}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("ready_low_at_release", {31'b0, req_ready}, 32'h0);
    @(posedge clk);
    #1 check("ready_one_edge_after", {31'b0, req_ready}, 32'h1);
    check("rst_no_write", wr_cnt - w0, 32'd0);
    check("rst_word2_kept", mem[2], 32'h55555555);
    send(mk(0, 2'b10, 0, 32'h08, 32'h0, 32'h55555555, 0, 3), 1'b1);
    send(mk(1, 2'b00, 0, 32'h08, 32'h00000012, 32'h0, 0, 4), 1'b1);
    send(mk(0, 2'b10, 0, 32'h08, 32'h0, 32'h55555512, 0, 3), 1'b1);
    req_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
